// File: rtl/nco_phase_fold_q22.sv
// nco_phase_fold_q22
//   Numerically controlled phase generator. A binary-angle accumulator
//   (2^PHASE_W = one turn) advances by the increment register on every
//   accepted tick. The phase is folded into [-1/4, +1/4] turn, which keeps
//   sin() unchanged. It is then scaled by 2*pi into signed Q2.22 radians.
//   There are three pipeline stages with valid/ready backpressure on the output.
//
// Ports
//   clk, rst        single clock, synchronous active-high reset
//   freq_we         load phase_inc_i into the increment register
//   phase_inc_i     phase increment per sample (turns * 2^PHASE_W)
//   phase_sync      force the accumulator to phase_offset_i
//   phase_offset_i  sync load value
//   tick            sample request; accepted when tick && tick_ready
//   tick_ready      low while the output stage is stalled
//   theta_out       signed Q2.22 radians in [-pi/2, +pi/2]
//   quad_out        top two phase bits of the emitted sample
//   out_valid       theta_out/quad_out valid
//   out_ready       downstream accept
module nco_phase_fold_q22 #(
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned TWO_PI  = 26353589
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freq_we,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic               phase_sync,
  input  logic [PHASE_W-1:0] phase_offset_i,
  input  logic               tick,
  output logic               tick_ready,
  output logic [23:0]        theta_out,
  output logic [1:0]         quad_out,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam logic [PHASE_W-1:0] HALF_TURN = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic signed [63:0] TWO_PI_S  = 64'(TWO_PI);
  localparam logic signed [63:0] ROUND_C   = 64'sd1 <<< (PHASE_W - 1);

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_q, inc_d;
  logic [PHASE_W-1:0] p0_q, p0_d;
  logic               v0_q, v0_d;
  logic signed [PHASE_W-1:0] f1_q, f1_d;
  logic [1:0]         q1_q, q1_d;
  logic               v1_q, v1_d;
  logic [23:0]        theta_q, theta_d;
  logic [1:0]         quad_q, quad_d;
  logic               v2_q, v2_d;

  logic               stall;
  logic               accept;
  logic [PHASE_W-1:0] acc_eff;
  logic [PHASE_W-1:0] fold;
  logic signed [63:0] prod;
  logic signed [63:0] rounded;

  always_comb begin
    acc_d   = acc_q;
    inc_d   = inc_q;
    p0_d    = p0_q;
    v0_d    = v0_q;
    f1_d    = f1_q;
    q1_d    = q1_q;
    v1_d    = v1_q;
    theta_d = theta_q;
    quad_d  = quad_q;
    v2_d    = v2_q;

    stall   = v2_q && !out_ready;
    accept  = tick && !stall;
    acc_eff = phase_sync ? phase_offset_i : acc_q;

    // Quadrants 1 and 2 are mirrored about 1/4 turn: sin(pi - x) = sin(x).
    fold    = (p0_q[PHASE_W-1] ^ p0_q[PHASE_W-2]) ? (HALF_TURN - p0_q) : p0_q;

    // The rounding offset is half of the LSB that survives the shift.
    // Adding it before the arithmetic shift rounds halves toward +inf.
    prod    = 64'(f1_q) * TWO_PI_S;
    rounded = prod + ROUND_C;

    // The increment register loads even during a stall. A tick accepted in
    // the same cycle still uses the old increment.
    if (freq_we) inc_d = phase_inc_i;

    if (!stall) begin
      if (accept) begin
        p0_d  = acc_eff;
        acc_d = acc_eff + inc_q;
      end else if (phase_sync) begin
        acc_d = phase_offset_i;
      end
      v0_d = accept;
      v1_d = v0_q;
      v2_d = v1_q;
      // The data registers load only for valid slots. A bubble therefore
      // leaves the outputs at their last value.
      if (v0_q) begin
        f1_d = fold;
        q1_d = p0_q[PHASE_W-1:PHASE_W-2];
      end
      if (v1_q) begin
        theta_d = 24'(rounded >>> PHASE_W);
        quad_d  = q1_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      inc_q   <= '0;
      p0_q    <= '0;
      v0_q    <= 1'b0;
      f1_q    <= '0;
      q1_q    <= '0;
      v1_q    <= 1'b0;
      theta_q <= '0;
      quad_q  <= '0;
      v2_q    <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      inc_q   <= inc_d;
      p0_q    <= p0_d;
      v0_q    <= v0_d;
      f1_q    <= f1_d;
      q1_q    <= q1_d;
      v1_q    <= v1_d;
      theta_q <= theta_d;
      quad_q  <= quad_d;
      v2_q    <= v2_d;
    end
  end

  assign tick_ready = !stall;
  assign theta_out  = theta_q;
  assign quad_out   = quad_q;
  assign out_valid  = v2_q;

endmodule

// File: tb/tb_nco_phase_fold_q22.sv
// Bench for nco_phase_fold_q22. It uses a cycle model of the accumulator and
// the valid pipeline. Expected samples are queued when a tick is accepted.
// They are compared while they sit on the output and popped when consumed.
module tb_nco_phase_fold_q22;

  logic        clk = 1'b0;
  logic        rst;
  logic        freq_we;
  logic [31:0] phase_inc_i;
  logic        phase_sync;
  logic [31:0] phase_offset_i;
  logic        tick;
  logic        tick_ready;
  logic [23:0] theta_out;
  logic [1:0]  quad_out;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  nco_phase_fold_q22 #(.PHASE_W(32), .TWO_PI(26353589)) dut (
    .clk            (clk),
    .rst            (rst),
    .freq_we        (freq_we),
    .phase_inc_i    (phase_inc_i),
    .phase_sync     (phase_sync),
    .phase_offset_i (phase_offset_i),
    .tick           (tick),
    .tick_ready     (tick_ready),
    .theta_out      (theta_out),
    .quad_out       (quad_out),
    .out_valid      (out_valid),
    .out_ready      (out_ready)
  );

  typedef struct {
    logic [23:0] th;
    logic [1:0]  qd;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_hold;
  logic [31:0] m_acc;
  logic [31:0] m_inc;
  logic        mv0, mv1, mv2;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // Expected output for a phase: fold about 1/4 turn, then multiply by
  // round(2*pi*2^22). Round half up and drop the 32 fraction bits.
  function automatic exp_t model(input logic [31:0] p);
    logic [31:0] f;
    longint      prod;
    longint      t;
    exp_t        e;
    f    = (p[31] ^ p[30]) ? (32'h8000_0000 - p) : p;
    prod = longint'($signed(f)) * 64'sd26353589;
    t    = (prod + 64'sd2147483648) >>> 32;
    e.th = t[23:0];
    e.qd = p[31:30];
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc  = '0;
    m_inc  = '0;
    mv0    = 1'b0;
    mv1    = 1'b0;
    mv2    = 1'b0;
    m_hold = '{th: '0, qd: '0};
    sb.delete();
  endtask

  // One clock cycle. Outputs are checked on the falling edge. The model then
  // advances with the inputs that the DUT sees at the rising edge.
  task automatic cyc();
    logic        stall;
    logic [31:0] eff;
    exp_t        e;
    @(negedge clk);
    stall = mv2 && !out_ready;
    chk("tick_ready", 32'(tick_ready), 32'(!stall));
    chk("out_valid", 32'(out_valid), 32'(mv2));
    if (mv2) begin
      if (sb.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL sb_underflow: observed valid output expected no pending sample");
      end else begin
        chk("theta", 32'(theta_out), 32'(sb[0].th));
        chk("quad", 32'(quad_out), 32'(sb[0].qd));
        if (out_ready) begin
          e      = sb.pop_front();
          m_hold = e;
        end
      end
    end else begin
      chk("theta_hold", 32'(theta_out), 32'(m_hold.th));
      chk("quad_hold", 32'(quad_out), 32'(m_hold.qd));
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (!stall) begin
        eff = phase_sync ? phase_offset_i : m_acc;
        if (tick) begin
          sb.push_back(model(eff));
          m_acc = eff + m_inc;
        end else if (phase_sync) begin
          m_acc = phase_offset_i;
        end
        mv2 = mv1;
        mv1 = mv0;
        mv0 = tick;
      end
      if (freq_we) m_inc = phase_inc_i;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic load_inc(input logic [31:0] v);
    freq_we     = 1'b1;
    phase_inc_i = v;
    cyc();
    freq_we     = 1'b0;
  endtask

  task automatic drain();
    tick = 1'b0;
    out_ready = 1'b1;
    repeat (5) cyc();
  endtask

  initial begin
    rst            = 1'b1;
    freq_we        = 1'b0;
    phase_inc_i    = '0;
    phase_sync     = 1'b0;
    phase_offset_i = '0;
    tick           = 1'b0;
    out_ready      = 1'b1;
    // The first edge establishes a known state. Checking starts after it.
    @(posedge clk);
    #1;
    model_reset();
    cyc();
    rst = 1'b0;

    // 1: quarter-turn steps give 0, +max, 0, -max, 0.
    load_inc(32'h4000_0000);
    tick = 1'b1;
    repeat (5) cyc();
    drain();

    // 2: eighth-turn steps, including the fold of 3/8 turn.
    do_reset();
    load_inc(32'h2000_0000);
    tick = 1'b1;
    repeat (4) cyc();
    drain();

    // 3: output stall with tick held high.
    do_reset();
    load_inc(32'h4000_0000);
    tick = 1'b1;
    repeat (4) cyc();
    out_ready = 1'b0;
    repeat (5) cyc();
    out_ready = 1'b1;
    repeat (4) cyc();
    drain();

    // 4: phase_sync together with a tick.
    do_reset();
    load_inc(32'h4000_0000);
    phase_sync     = 1'b1;
    phase_offset_i = 32'h4000_0000;
    tick           = 1'b1;
    cyc();
    phase_sync = 1'b0;
    cyc();
    drain();

    // 5: increment change in the same cycle as a tick; phase_sync alone.
    do_reset();
    load_inc(32'h1000_0000);
    freq_we     = 1'b1;
    phase_inc_i = 32'h4000_0000;
    tick        = 1'b1;
    cyc();
    freq_we = 1'b0;
    repeat (3) cyc();
    tick           = 1'b0;
    phase_sync     = 1'b1;
    phase_offset_i = 32'hC000_0000;
    cyc();
    phase_sync = 1'b0;
    tick       = 1'b1;
    repeat (2) cyc();
    drain();

    // 6: the accumulator wraps downward; reset is asserted mid-stream.
    do_reset();
    load_inc(32'hFFFF_FFFF);
    tick = 1'b1;
    repeat (6) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (4) cyc();
    drain();

    // 7: random increments, ticks and backpressure.
    do_reset();
    load_inc($urandom);
    for (int i = 0; i < 80; i++) begin
      tick        = 1'($urandom_range(0, 3) != 0);
      out_ready   = 1'($urandom_range(0, 2) != 0);
      freq_we     = 1'($urandom_range(0, 9) == 0);
      phase_inc_i = $urandom;
      phase_sync  = 1'($urandom_range(0, 15) == 0);
      phase_offset_i = $urandom;
      cyc();
    end
    freq_we    = 1'b0;
    phase_sync = 1'b0;
    drain();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
